// File: rtl/store_controller_pkg.sv
// Shared definitions for the result-tile store controller.
package store_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } store_state_t;

    localparam logic RDWR_WRITE = 1'b1;

endpackage : store_controller_pkg

// File: rtl/store_controller_if.sv
// Store-path bundle between the store controller, the execute control and the memory interface.
interface store_controller_if;

    logic        can_store;
    logic [31:0] tile_C_addr;
    logic [31:0] tile_C_stride;
    logic [4:0]  msize;
    logic [4:0]  nsize;
    logic        row_valid;
    logic        interface_ready;

    logic        gen_addr_store;
    logic        interface_en_store;
    logic        interface_rdwr_store;
    logic [4:0]  interface_control_store;
    logic [31:0] next_row_addr_store;
    logic        row_pop;
    logic        done_store;
    logic        busy;

    modport master (
        input  can_store, tile_C_addr, tile_C_stride, msize, nsize,
               row_valid, interface_ready,
        output gen_addr_store, interface_en_store, interface_rdwr_store,
               interface_control_store, next_row_addr_store, row_pop,
               done_store, busy
    );

    modport slave (
        output can_store, tile_C_addr, tile_C_stride, msize, nsize,
               row_valid, interface_ready,
        input  gen_addr_store, interface_en_store, interface_rdwr_store,
               interface_control_store, next_row_addr_store, row_pop,
               done_store, busy
    );

endinterface : store_controller_if

// File: rtl/store_controller.sv
// Writes msize result rows out to memory, one request per cycle when a row and the interface are ready.
//
//   state    | meaning
//   ST_IDLE  | waiting for can_store; latches the tile configuration
//   ST_ISSUE | issuing one row write whenever row_valid & interface_ready
//   ST_DONE  | one-cycle done_store pulse, then back to idle
module store_controller
    import store_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    store_controller_if.master bus
);

    store_state_t r_state;
    store_state_t w_next_state;

    logic [31:0] r_addr;
    logic [31:0] r_stride;
    logic [4:0]  r_msize;
    logic [4:0]  r_nsize;
    logic [4:0]  r_row_cnt;
    logic [31:0] r_last_addr;
    logic [4:0]  r_last_ctrl;

    logic w_issue;
    logic w_last_row;

    assign w_issue    = (r_state == ST_ISSUE) & bus.row_valid & bus.interface_ready & bus.can_store;
    assign w_last_row = (r_row_cnt == (r_msize - 5'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The last issued address/size are kept so the outputs hold between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_stride    <= '0;
            r_msize     <= '0;
            r_nsize     <= '0;
            r_row_cnt   <= '0;
            r_last_addr <= '0;
            r_last_ctrl <= '0;
        end else if ((r_state == ST_IDLE) && bus.can_store) begin
            r_addr    <= bus.tile_C_addr;
            r_stride  <= bus.tile_C_stride;
            r_msize   <= bus.msize;
            r_nsize   <= bus.nsize;
            r_row_cnt <= '0;
        end else if (w_issue) begin
            r_addr      <= r_addr + r_stride;
            r_row_cnt   <= r_row_cnt + 5'd1;
            r_last_addr <= r_addr;
            r_last_ctrl <= r_nsize;
        end
    end

    always_comb begin
        w_next_state                = r_state;
        bus.gen_addr_store          = 1'b0;
        bus.interface_en_store      = 1'b0;
        bus.interface_rdwr_store    = 1'b0;
        bus.row_pop                 = 1'b0;
        bus.next_row_addr_store     = r_last_addr;
        bus.interface_control_store = r_last_ctrl;
        bus.done_store              = 1'b0;
        bus.busy                    = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (bus.can_store) begin
                    w_next_state = (bus.msize == 5'd0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.can_store) begin
                    w_next_state = ST_IDLE;
                end else if (w_issue) begin
                    bus.gen_addr_store          = 1'b1;
                    bus.interface_en_store      = 1'b1;
                    bus.interface_rdwr_store    = RDWR_WRITE;
                    bus.row_pop                 = 1'b1;
                    bus.next_row_addr_store     = r_addr;
                    bus.interface_control_store = r_nsize;
                    if (w_last_row) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                bus.done_store = 1'b1;
                w_next_state   = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule : store_controller

// File: doc/store_controller.md
STORE_CONTROLLER -- requirements
Module: store_controller

Interface
REQ-001 clk  in  1  clock; single clock domain, all state updates on rising edge.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 can_store  in  1  store grant from load/execute controller; held high for the whole store window.
REQ-004 tile_C_addr  in  32  base byte address of result tile C (row 0).
REQ-005 tile_C_stride  in  32  address increment between consecutive result rows.
REQ-006 msize  in  5  number of result rows to store.
REQ-007 nsize  in  5  elements per result row; forwarded as the interface transfer size.
REQ-008 row_valid  in  1  result buffer holds a complete row ready for write-out.
REQ-009 interface_ready  in  1  memory interface can accept a request this cycle.
REQ-010 gen_addr_store  out  1  load next_row_addr_store into the address generator.
REQ-011 interface_en_store  out  1  memory interface request strobe.
REQ-012 interface_rdwr_store  out  1  1 = write, 0 = read.
REQ-013 interface_control_store  out  5  transfer size for the current request.
REQ-014 next_row_addr_store  out  32  address of the row being written.
REQ-015 row_pop  out  1  dequeue one row from the result buffer.
REQ-016 done_store  out  1  one-cycle pulse: all msize rows issued.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE and DONE.
REQ-019 IDLE: on can_store=1 at a clock edge, latch tile_C_addr into addr_reg, tile_C_stride, msize and nsize; clear row_cnt; go to ISSUE (msize!=0) or DONE (msize==0).
REQ-020 ISSUE: issue = row_valid & interface_ready & can_store, evaluated combinationally.
REQ-021 On issue, gen_addr_store, interface_en_store, interface_rdwr_store and row_pop SHALL all be 1 in the same cycle; next_row_addr_store=addr_reg; interface_control_store=latched nsize.
REQ-022 When issue=0, those four strobes SHALL be 0; next_row_addr_store and interface_control_store hold their last values.
REQ-023 On issue: addr_reg <= addr_reg + stride, modulo 2^32 (wrap silently); row_cnt <= row_cnt + 1.
REQ-024 Issue with row_cnt == msize-1 SHALL transition to DONE; otherwise stay in ISSUE.
REQ-025 Throughput: one row per cycle while row_valid and interface_ready are held high; latency from can_store to the first strobe is 1 cycle minimum.
REQ-026 DONE: done_store=1 for exactly one cycle with no strobe asserted; go to IDLE the next cycle.
REQ-027 can_store=0 while in ISSUE SHALL abort: go to IDLE, no strobe, no done_store.
REQ-028 Input changes to tile_C_addr, tile_C_stride, msize or nsize after the latch SHALL NOT affect the running store.
REQ-029 After DONE, a new store SHALL start only on a fresh can_store sample in IDLE.

Reset
REQ-030 rst=1 SHALL force IDLE in all states, including mid-ISSUE.
REQ-031 On reset, all outputs SHALL be 0, and addr_reg, row_cnt and the latched fields SHALL be 0.

Structure
REQ-032 The state enum and the RDWR_WRITE=1 constant SHALL live in the shared controller package.
REQ-033 No sub-module is required; the row counter and address register are inline.

Verification
REQ-034 msize=4, nsize=8, addr=0x1000, stride=0x40, row_valid=interface_ready=1 -> strobes on 4 consecutive cycles, addresses 0x1000/0x1040/0x1080/0x10C0, control=8, done_store one cycle later.
REQ-035 Same config, row_valid toggling 1,0,1,0,... -> 4 issues on alternate cycles, addresses unchanged from REQ-034, exactly 4 row_pop.
REQ-036 msize=0 with can_store pulse -> no strobe, done_store 1 cycle after the IDLE sample.
REQ-037 addr=0xFFFFFFC0, stride=0x40, msize=2 -> addresses 0xFFFFFFC0 then 0x00000000.
REQ-038 msize=8; drop can_store after 3 issues -> IDLE, no done_store, busy=0; rst asserted mid-ISSUE -> all outputs 0 the next cycle.
